// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package mdu_pkg;

  // Operation encodings on op_i
  localparam logic [1:0] MDU_OP_MULT  = 2'b00;
  localparam logic [1:0] MDU_OP_MULTU = 2'b01;
  localparam logic [1:0] MDU_OP_DIV   = 2'b10;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

  // Controller states
  typedef logic [2:0] mdu_state_t;
  localparam mdu_state_t MDU_IDLE = 3'd0;
  localparam mdu_state_t MDU_MUL  = 3'd1;
  localparam mdu_state_t MDU_DIV  = 3'd2;
  localparam mdu_state_t MDU_FIX  = 3'd3;
  localparam mdu_state_t MDU_DONE = 3'd4;

  // EX-side aluop (funct) codes that route to this unit
  localparam logic [5:0] ALUOP_MULT  = 6'h18;
  localparam logic [5:0] ALUOP_MULTU = 6'h19;
  localparam logic [5:0] ALUOP_DIV   = 6'h1a;
  localparam logic [5:0] ALUOP_DIVU  = 6'h1b;

  // The funct codes were chosen so their low two bits are the mdu op.
  function automatic logic [1:0] aluop_to_mdu_op(input logic [5:0] aluop);
    return aluop[1:0];
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Latency: WIDTH cycles after the load edge; last is high during the final iteration cycle.
// Backpressure: none; kill aborts the run, load restarts it.
// Ports: clk, rst (sync, active-high), load/kill controls, dividend/divisor in,
//        quot/rem out (stable once the run ends), last out.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             kill,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  assign trial = {r_r, q_r[WIDTH-1]} - {1'b0, d_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      r_r    <= '0;
      d_r    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (kill) begin
      active <= 1'b0;
    end else if (load) begin
      q_r    <= dividend;
      r_r    <= '0;
      d_r    <= divisor;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (!trial[WIDTH]) begin
        r_r <= trial[WIDTH-1:0];
        q_r <= {q_r[WIDTH-2:0], 1'b1};
      end else begin
        // Dropping r_r's MSB is safe: if it were set the subtract could not borrow.
        r_r <= {r_r[WIDTH-2:0], q_r[WIDTH-1]};
        q_r <= {q_r[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) active <= 1'b0;
    end
  end

  assign last = active && (cnt == CW'(WIDTH - 1));
  assign quot = q_r;
  assign rem  = r_r;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed/unsigned multiply/divide for EX; result returned as {HI,LO}.
// Latency: MUL_CYCLES cycles for MULT/MULTU, WIDTH+2 for DIV/DIVU, accept edge to done_o.
// Backpressure: busy_o stalls EX; start_i is accepted only in IDLE or DONE, flush_i aborts.
// Ports: clk, rst (sync, active-high), start_i/op_i/flush_i, operand_a_i/operand_b_i,
//        busy_o, done_o, hi_o, lo_o, div_by_zero_o.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  import mdu_pkg::*;

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam int PD = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;

  mdu_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    mul_cnt;
  logic             div_first;
  logic             accept;

  assign accept = start_i && !flush_i && (state == MDU_IDLE || state == MDU_DONE);
  assign busy_o = (state == MDU_MUL) || (state == MDU_DIV) || (state == MDU_FIX);
  assign done_o = (state == MDU_DONE);

  // ---------------- multiply datapath ----------------
  logic             sgn;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, prod, mul_res;
  logic [2*WIDTH-1:0] mul_pipe [PD];

  assign sgn       = is_signed_op(op_q);
  // Extending to 2W then taking the low 2W product bits is exact for both signednesses.
  assign mul_a_ext = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign mul_b_ext = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod      = mul_a_ext * mul_b_ext;

  // Operands stay stable for the whole MUL state, so the pipe can shift freely.
  always_ff @(posedge clk) begin
    mul_pipe[0] <= prod;
    for (int i = 1; i < PD; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  // The output register is the last stage; the pipe supplies the ones before it.
  assign mul_res = (MUL_CYCLES == 1) ? prod : mul_pipe[PD-1];

  // ---------------- divide datapath ----------------
  logic             a_neg, b_neg, neg_q, dbz;
  logic [WIDTH-1:0] a_mag, b_mag, quot, rem, q_fix, r_fix;
  logic             div_load, div_last;

  assign a_neg = sgn && a_q[WIDTH-1];
  assign b_neg = sgn && b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign neg_q = a_neg ^ b_neg;
  assign dbz   = op_q[1] && (b_q == '0);

  // Magnitudes are loaded one cycle after accept, from the latched operands.
  assign div_load = (state == MDU_DIV) && div_first;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .kill     (flush_i),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quot     (quot),
    .rem      (rem),
    .last     (div_last)
  );

  // Quotient is negative when signs differ; remainder follows the dividend.
  assign q_fix = neg_q ? -quot : quot;
  assign r_fix = a_neg ? -rem : rem;

  // ---------------- control ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (accept) state_nxt = is_div_op(op_i) ? MDU_DIV : MDU_MUL;
      MDU_MUL:  if (flush_i) state_nxt = MDU_IDLE;
                else if (mul_cnt == CW'(MUL_CYCLES)) state_nxt = MDU_DONE;
      MDU_DIV:  if (flush_i) state_nxt = MDU_IDLE;
                else if (div_last) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = flush_i ? MDU_IDLE : MDU_DONE;
      MDU_DONE: state_nxt = accept ? (is_div_op(op_i) ? MDU_DIV : MDU_MUL) : MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= MDU_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      mul_cnt       <= '0;
      div_first     <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_first <= accept;
      if (accept) begin
        a_q     <= operand_a_i;
        b_q     <= operand_b_i;
        op_q    <= op_i;
        mul_cnt <= CW'(1);
      end else if (state == MDU_MUL) begin
        mul_cnt <= mul_cnt + 1'b1;
      end
      // Results change only on the edge entering DONE.
      if (state == MDU_MUL && state_nxt == MDU_DONE) begin
        {hi_o, lo_o}  <= mul_res;
        div_by_zero_o <= 1'b0;
      end else if (state == MDU_FIX && !flush_i) begin
        hi_o          <= dbz ? a_q : r_fix;
        lo_o          <= dbz ? '1  : q_fix;
        div_by_zero_o <= dbz;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops vs an arithmetic model.
// Latency: checks exact done_o timing and busy_o duration for every operation.
// Backpressure: exercises back-to-back starts, flushes in busy and DONE, and mid-op reset.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic         flush_i;
  logic [W-1:0] operand_a_i, operand_b_i;
  logic         busy_o, done_o, div_by_zero_o;
  logic [W-1:0] hi_o, lo_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dbz = 1'b0;

  mul_div_unit #(.WIDTH(W), .MUL_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .op_i          (op_i),
    .flush_i       (flush_i),
    .operand_a_i   (operand_a_i),
    .operand_b_i   (operand_b_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: plain signed/unsigned 64-bit math.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dbz = 1'b0;
    case (op)
      2'b00: begin sp = sa * sb; v = sp; hi = v[63:32]; lo = v[31:0]; end
      2'b01: begin up = ua * ub; v = up; hi = v[63:32]; lo = v[31:0]; end
      default: begin
        if (b == '0) begin
          hi = a; lo = '1; dbz = 1'b1;
        end else if (op == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          v = sq; lo = v[31:0];
          v = sr; hi = v[31:0];
        end else begin
          v = ua / ub; lo = v[31:0];
          v = ua % ub; hi = v[31:0];
        end
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle (or after timeout).
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, busy_cnt, exp_lat;
    op_i = op; operand_a_i = a; operand_b_i = b; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    exp_lat = op[1] ? W + 2 : 2;
    model(op, a, b, exp_hi, exp_lo, exp_dbz);
    lat = -1; busy_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      if (done_o) begin lat = k; break; end
      if (busy_o) busy_cnt++;
      @(negedge clk);
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_cycles"}, busy_cnt, exp_lat);
    check({tag, ".busy_in_done"}, busy_o, 1'b0);
    check({tag, ".hi"}, hi_o, exp_hi);
    check({tag, ".lo"}, lo_o, exp_lo);
    check({tag, ".dbz"}, div_by_zero_o, exp_dbz);
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           dones;

    rst = 1'b1; start_i = 1'b1; flush_i = 1'b0; op_i = 2'b10;
    operand_a_i = 32'd5; operand_b_i = 32'd1;
    repeat (3) @(negedge clk);
    check("reset.busy", busy_o, 1'b0);
    check("reset.done", done_o, 1'b0);
    check("reset.hi", hi_o, '0);
    check("reset.lo", lo_o, '0);
    check("reset.dbz", div_by_zero_o, 1'b0);
    start_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg", 2'b00, 32'hFFFFFFFE, 32'd3);
    @(negedge clk);
    check("hold.done", done_o, 1'b0);
    check("hold.hi", hi_o, 32'hFFFFFFFF);
    check("hold.lo", lo_o, 32'hFFFFFFFA);

    run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
    @(negedge clk);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF);
    @(negedge clk);
    run_op("div_by0", 2'b10, 32'h1234, 32'd0);
    run_op("divu_by0", 2'b11, 32'h8000_0001, 32'd0);

    // Reset in the middle of a divide clears everything on the next cycle.
    op_i = 2'b10; operand_a_i = 32'd77; operand_b_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.busy", busy_o, 1'b0);
    check("midrst.done", done_o, 1'b0);
    check("midrst.hi", hi_o, '0);
    check("midrst.lo", lo_o, '0);
    check("midrst.dbz", div_by_zero_o, 1'b0);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    @(negedge clk);

    run_op("pre_flush", 2'b01, 32'd9, 32'd11);
    @(negedge clk);

    // Flush at cycle +10 of a DIVU, with a start on the same cycle.
    op_i = 2'b11; operand_a_i = 32'd100; operand_b_i = 32'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1; start_i = 1'b1; op_i = 2'b00; operand_a_i = 32'd3; operand_b_i = 32'd3;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    check("flush.busy", busy_o, 1'b0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_o || busy_o) dones++;
      @(negedge clk);
    end
    check("flush.no_activity", dones, 0);
    check("flush.hi", hi_o, exp_hi);
    check("flush.lo", lo_o, exp_lo);

    // Flush during DONE: pulse is seen, new start is dropped.
    run_op("done_flush", 2'b00, 32'd5, 32'd6);
    flush_i = 1'b1; start_i = 1'b1; op_i = 2'b10; operand_a_i = 32'd8; operand_b_i = 32'd2;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    check("done_flush.busy", busy_o, 1'b0);
    check("done_flush.done", done_o, 1'b0);
    check("done_flush.lo", lo_o, 32'd30);

    // Back-to-back: MULTU issued in the DIV DONE cycle.
    @(negedge clk);
    run_op("b2b_div", 2'b10, 32'd1000, 32'hFFFFFFFD);
    run_op("b2b_multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("b2b.hi_const", hi_o, 32'hFFFFFFFE);
    check("b2b.lo_const", lo_o, 32'h00000001);

    // Randomized operations, some back-to-back, some with idle gaps.
    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      run_op($sformatf("rand%0d", n), rop, ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
